l2_bank_slave_port: RTL

- Memory-bank end of the L2 crossbar: takes request channels from N_MASTER initiator-side decoders, arbitrates round-robin onto one L2 SRAM bank, and returns the response.
- Returns the response one cycle later to the granted initiator's channel, tagged with that initiator's ID.
- One instance per L2 bank.
- Complements the initiator-side request decode/response merge: this block is the responder end of the same req/gnt/r_valid protocol.

---
 rtl/l2_xbar_pkg.sv | 16 +
 rtl/l2_rr_arb_core.sv | 36 +++
 rtl/l2_bank_slave_port.sv | 127 ++++++++++++
 3 files changed

// File: rtl/l2_xbar_pkg.sv
// Shared helpers for the L2 crossbar: round-robin wrap arithmetic and
// index-width sizing used by the bank-side slave port and its arbiter.
package l2_xbar_pkg;

  // Width of an index able to address n channels (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index following idx in a ring of n entries; the explicit compare keeps
  // the wrap correct when n is not a power of two.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/l2_rr_arb_core.sv
// Combinational round-robin search: returns the first requesting channel
// at or after ptr, wrapping modulo N, plus a flag telling whether any
// channel requested at all. Holds no state; the pointer lives in the caller.
module l2_rr_arb_core
  import l2_xbar_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  // One extra bit so ptr + offset never overflows before the wrap compare.
  logic [IDX_W:0] cand;

  // Scan offsets 0..N-1 from ptr and latch the first requester found.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N)) begin
        cand = cand - (IDX_W + 1)'(N);
      end
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/l2_bank_slave_port.sv
// Bank end of the L2 crossbar. Arbitrates N_MASTER request channels
// round-robin onto a single SRAM bank and returns the response one cycle
// after the grant, on the granted channel, tagged with the request ID.
module l2_bank_slave_port
  import l2_xbar_pkg::*;
#(
  parameter int unsigned N_MASTER   = 4,
  parameter int unsigned ID_WIDTH   = N_MASTER,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_MASTER-1:0]            data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
  input  logic [N_MASTER-1:0]            data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
  input  logic [N_MASTER*ID_WIDTH-1:0]   data_ID_i,
  output logic [N_MASTER-1:0]            data_gnt_o,
  output logic [N_MASTER-1:0]            data_r_valid_o,
  output logic [ID_WIDTH-1:0]            data_r_ID_o,
  output logic [DATA_WIDTH-1:0]          data_r_rdata_o,
  output logic                           mem_req_o,
  input  logic                           mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]          mem_add_o,
  output logic                           mem_wen_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  output logic [BE_WIDTH-1:0]            mem_be_o,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

  localparam int unsigned IDX_W = idx_width(N_MASTER);

  // Everything one channel presents alongside its request.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic [ID_WIDTH-1:0]   id;
  } req_bundle_t;

  req_bundle_t          bundles [N_MASTER];
  req_bundle_t          sel;
  logic [IDX_W-1:0]     winner;
  logic                 any_req;
  logic                 hs;

  logic [IDX_W-1:0]     rr_ptr_q;
  logic                 resp_valid_q;
  logic [IDX_W-1:0]     resp_idx_q;
  logic [ID_WIDTH-1:0]  resp_id_q;

  // Regroup the flat per-channel buses into one bundle per channel.
  for (genvar g = 0; g < int'(N_MASTER); g++) begin : g_unpack
    assign bundles[g] = '{
      add:   data_add_i[g*ADDR_WIDTH +: ADDR_WIDTH],
      wen:   data_wen_i[g],
      wdata: data_wdata_i[g*DATA_WIDTH +: DATA_WIDTH],
      be:    data_be_i[g*BE_WIDTH +: BE_WIDTH],
      id:    data_ID_i[g*ID_WIDTH +: ID_WIDTH]
    };
  end

  l2_rr_arb_core #(
    .N (N_MASTER)
  ) u_arb (
    .req    (data_req_i),
    .ptr    (rr_ptr_q),
    .winner (winner),
    .valid  (any_req)
  );

  // With no requester the arbiter reports index 0, so the bank pins simply
  // follow channel 0 while mem_req_o stays low.
  assign sel         = bundles[winner];
  assign mem_req_o   = any_req;
  assign mem_add_o   = sel.add;
  assign mem_wen_o   = sel.wen;
  assign mem_wdata_o = sel.wdata;
  assign mem_be_o    = sel.be;

  // A transfer happens only when someone asks and the bank is not stalled.
  assign hs = any_req & mem_gnt_i;

  // Grant goes to the arbitration winner and only on an actual handshake.
  always_comb begin
    data_gnt_o         = '0;
    data_gnt_o[winner] = hs;
  end

  // Advance the round-robin pointer past each served channel; a stall holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (hs) begin
      rr_ptr_q <= IDX_W'(rr_next(32'(winner), N_MASTER));
    end
  end

  // Remember who was served so the response returns to them next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_id_q    <= '0;
    end else begin
      resp_valid_q <= hs;
      if (hs) begin
        resp_idx_q <= winner;
        resp_id_q  <= sel.id;
      end
    end
  end

  // Response valid is one-hot toward the channel granted last cycle.
  always_comb begin
    data_r_valid_o             = '0;
    data_r_valid_o[resp_idx_q] = resp_valid_q;
  end

  assign data_r_ID_o    = resp_id_q;
  assign data_r_rdata_o = mem_rdata_i;

endmodule
